// File: rtl/ysyx_24120013_pkg.sv
// Shared types and constants for the write-back stage and its GPR file.
package ysyx_24120013_pkg;

  localparam int ADDR_WIDTH_DEF = 5;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int CNT_WIDTH_DEF  = 64;
  localparam int GPR_NUM        = 2 ** ADDR_WIDTH_DEF;
  localparam int REG_ZERO       = 0;

  // Entry held between accept and commit.
  typedef struct packed {
    logic                      wen;
    logic [ADDR_WIDTH_DEF-1:0] waddr;
    logic [DATA_WIDTH_DEF-1:0] wdata;
  } pend_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_t;

endpackage

// File: rtl/ysyx_24120013_wbu_if.sv
// Execute -> write-back result handshake.
interface ysyx_24120013_wbu_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  exu_valid;
  logic                  exu_ready;
  logic                  exu_wen;
  logic [ADDR_WIDTH-1:0] exu_waddr;
  logic [DATA_WIDTH-1:0] exu_wdata;

  modport master (output exu_valid, exu_wen, exu_waddr, exu_wdata, input exu_ready);
  modport slave  (input exu_valid, exu_wen, exu_waddr, exu_wdata, output exu_ready);
endinterface

// File: rtl/ysyx_24120013_gpr.sv
// General-purpose register array: one write port (x0 gated), two raw async read ports.
module ysyx_24120013_gpr
  import ysyx_24120013_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2
);

  localparam int unsigned NREG = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && waddr != ADDR_WIDTH'(REG_ZERO)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

endmodule

// File: rtl/ysyx_24120013_wbu.sv
// Write-back stage: single pending-entry register, GPR commit with read bypass, instret counter.
module ysyx_24120013_wbu
  import ysyx_24120013_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  ysyx_24120013_wbu_if.slave    exu,
  input  logic                  wb_stall,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  output logic [DATA_WIDTH-1:0] rdata1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata2,
  output logic                  wb_valid,
  output logic [ADDR_WIDTH-1:0] wb_waddr,
  output logic [DATA_WIDTH-1:0] wb_wdata,
  output logic [CNT_WIDTH-1:0]  instret
);

  stage_state_t          state, state_nxt;
  pend_t                 pend;
  logic                  pend_valid;
  logic                  accept;
  logic                  commit;
  logic                  bypass1, bypass2;
  logic [DATA_WIDTH-1:0] gpr_rdata1, gpr_rdata2;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    pend_valid    = (state == ST_FULL);
    exu.exu_ready = !pend_valid || !wb_stall;
    accept        = exu.exu_valid && exu.exu_ready;
    commit        = pend_valid && !wb_stall;
    case (state)
      ST_EMPTY: if (accept) state_nxt = ST_FULL;
      ST_FULL:  if (commit && !accept) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= '0;
      wb_valid <= 1'b0;
      wb_waddr <= '0;
      wb_wdata <= '0;
      instret  <= '0;
    end else begin
      if (accept) begin
        pend.wen   <= exu.exu_wen;
        pend.waddr <= exu.exu_waddr;
        pend.wdata <= exu.exu_wdata;
      end
      wb_valid <= commit;
      if (commit) begin
        wb_waddr <= (pend.wen && pend.waddr != ADDR_WIDTH'(REG_ZERO)) ? pend.waddr : '0;
        wb_wdata <= pend.wdata;
        instret  <= instret + CNT_WIDTH'(1);
      end
    end
  end

  ysyx_24120013_gpr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_gpr (
    .clk    (clk),
    .rst    (rst),
    .we     (commit && pend.wen),
    .waddr  (pend.waddr),
    .wdata  (pend.wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (gpr_rdata1),
    .rdata2 (gpr_rdata2)
  );

  // Pending entry is newer than the array, so it wins even while stalled.
  assign bypass1 = pend_valid && pend.wen && (pend.waddr == raddr1);
  assign bypass2 = pend_valid && pend.wen && (pend.waddr == raddr2);

  assign rdata1 = (raddr1 == ADDR_WIDTH'(REG_ZERO)) ? '0 : (bypass1 ? pend.wdata : gpr_rdata1);
  assign rdata2 = (raddr2 == ADDR_WIDTH'(REG_ZERO)) ? '0 : (bypass2 ? pend.wdata : gpr_rdata2);

endmodule

// File: tb/tb_ysyx_24120013_wbu.sv
// Self-checking bench for the write-back stage: directed scenarios plus a randomized run.
module tb_ysyx_24120013_wbu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_stall = 1'b0;
  logic [4:0]  raddr1 = '0, raddr2 = '0;
  logic [31:0] rdata1, rdata2;
  logic        wb_valid;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic [63:0] instret;

  ysyx_24120013_wbu_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) exu ();

  ysyx_24120013_wbu #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .CNT_WIDTH(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .exu      (exu),
    .wb_stall (wb_stall),
    .raddr1   (raddr1),
    .rdata1   (rdata1),
    .raddr2   (raddr2),
    .rdata2   (rdata2),
    .wb_valid (wb_valid),
    .wb_waddr (wb_waddr),
    .wb_wdata (wb_wdata),
    .instret  (instret)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: architectural register values, a queue of at most one uncommitted result.
  typedef struct { bit wen; bit [4:0] a; bit [31:0] d; } ent_t;
  ent_t      pq[$];
  bit [31:0] gpr_m [32];
  bit [63:0] m_ir;
  bit        m_wbv;
  bit [4:0]  m_wba;
  bit [31:0] m_wbd;

  function automatic bit [31:0] m_read(bit [4:0] a);
    if (a == 0) return 32'h0;
    if (pq.size() != 0 && pq[0].wen && pq[0].a == a) return pq[0].d;
    return gpr_m[a];
  endfunction

  task automatic drive(input bit v, input bit w, input bit [4:0] a, input bit [31:0] d);
    exu.exu_valid = v;
    exu.exu_wen   = w;
    exu.exu_waddr = a;
    exu.exu_wdata = d;
  endtask

  // One clock edge; the model advances with the inputs seen just before it.
  task automatic step();
    bit   acc, com;
    ent_t e, c;
    com   = (pq.size() != 0) && !wb_stall;
    acc   = exu.exu_valid && (pq.size() == 0 || !wb_stall);
    e.wen = exu.exu_wen; e.a = exu.exu_waddr; e.d = exu.exu_wdata;
    @(posedge clk);
    if (rst) begin
      foreach (gpr_m[i]) gpr_m[i] = 0;
      pq.delete();
      m_ir = 0; m_wbv = 0; m_wba = 0; m_wbd = 0;
    end else begin
      m_wbv = com;
      if (com) begin
        c = pq.pop_front();
        if (c.wen && c.a != 0) gpr_m[c.a] = c.d;
        m_wba = (c.wen && c.a != 0) ? c.a : 5'd0;
        m_wbd = c.d;
        m_ir++;
      end
      if (acc) pq.push_back(e);
    end
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0);
    wb_stall = 0;
    rst = 1;
    step();
    step();
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a); raddr2 = 5'(31 - a);
      #1;
      checks++;
      if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
        failures++;
        $display("FAIL reset_gpr a=%0d rdata1=%h rdata2=%h exp=0", a, rdata1, rdata2);
      end
    end
    checks++;
    if (instret !== 64'd0 || wb_valid !== 1'b0 || exu.exu_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state instret=%0d wb_valid=%b ready=%b exp 0/0/1", instret, wb_valid, exu.exu_ready);
    end
  endtask

  task automatic test_single();
    do_reset();
    drive(1, 1, 5, 32'h1234_5678); raddr1 = 5;
    step();
    drive(0, 0, 0, 0);
    checks++;
    if (rdata1 !== 32'h1234_5678 || wb_valid !== 1'b0 || instret !== 64'd0) begin
      failures++;
      $display("FAIL single_bypass rdata1=%h wb_valid=%b instret=%0d exp 12345678/0/0", rdata1, wb_valid, instret);
    end
    step();
    checks++;
    if (wb_valid !== 1'b1 || wb_waddr !== 5'd5 || wb_wdata !== 32'h1234_5678 || instret !== 64'd1) begin
      failures++;
      $display("FAIL single_commit wb_valid=%b waddr=%0d wdata=%h instret=%0d exp 1/5/12345678/1", wb_valid, wb_waddr, wb_wdata, instret);
    end
    step();
    checks++;
    if (wb_valid !== 1'b0 || rdata1 !== 32'h1234_5678) begin
      failures++;
      $display("FAIL single_after wb_valid=%b rdata1=%h exp 0/12345678", wb_valid, rdata1);
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    do_reset();
    raddr1 = 1;
    for (int k = 1; k <= 3; k++) begin
      drive(1, 1, 1, 32'(k));
      step();
      pulses += int'(wb_valid);
      checks++;
      if (exu.exu_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready k=%0d ready=%b exp 1", k, exu.exu_ready);
      end
    end
    drive(0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      pulses += int'(wb_valid);
    end
    checks++;
    if (pulses != 3 || rdata1 !== 32'd3 || instret !== 64'd3) begin
      failures++;
      $display("FAIL b2b_final pulses=%0d x1=%0d instret=%0d exp 3/3/3", pulses, rdata1, instret);
    end
  endtask

  task automatic test_x0();
    do_reset();
    drive(1, 1, 0, 32'hFFFF_FFFF); raddr1 = 0;
    step();
    drive(0, 0, 0, 0);
    checks++;
    if (rdata1 !== 32'h0) begin
      failures++;
      $display("FAIL x0_pending rdata1=%h exp 0", rdata1);
    end
    step();
    checks++;
    if (wb_valid !== 1'b1 || wb_waddr !== 5'd0 || wb_wdata !== 32'hFFFF_FFFF || instret !== 64'd1 || rdata1 !== 32'h0) begin
      failures++;
      $display("FAIL x0_commit wb_valid=%b waddr=%0d wdata=%h instret=%0d x0=%h exp 1/0/ffffffff/1/0", wb_valid, wb_waddr, wb_wdata, instret, rdata1);
    end
  endtask

  task automatic test_stall();
    do_reset();
    wb_stall = 1;
    drive(1, 1, 7, 32'hA5); raddr1 = 7;
    step();
    drive(1, 1, 9, 32'h99);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (exu.exu_ready !== 1'b0 || rdata1 !== 32'hA5 || instret !== 64'd0 || wb_valid !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold i=%0d ready=%b rdata1=%h instret=%0d wb_valid=%b exp 0/a5/0/0", i, exu.exu_ready, rdata1, instret, wb_valid);
      end
      step();
    end
    drive(0, 0, 0, 0);
    wb_stall = 0;
    #1;
    checks++;
    if (exu.exu_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release_ready ready=%b exp 1", exu.exu_ready);
    end
    step();
    checks++;
    if (wb_valid !== 1'b1 || wb_waddr !== 5'd7 || instret !== 64'd1 || rdata1 !== 32'hA5) begin
      failures++;
      $display("FAIL stall_commit wb_valid=%b waddr=%0d instret=%0d rdata1=%h exp 1/7/1/a5", wb_valid, wb_waddr, instret, rdata1);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1, 1, 3, 32'h55); raddr1 = 3;
    step();
    drive(0, 0, 0, 0);
    rst = 1;
    step();
    checks++;
    if (instret !== 64'd0 || wb_valid !== 1'b0 || exu.exu_ready !== 1'b1 || rdata1 !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_during instret=%0d wb_valid=%b ready=%b rdata1=%h exp 0/0/1/0", instret, wb_valid, exu.exu_ready, rdata1);
    end
    rst = 0;
    step();
    checks++;
    if (wb_valid !== 1'b0 || rdata1 !== 32'h0 || instret !== 64'd0) begin
      failures++;
      $display("FAIL rstmid_after wb_valid=%b rdata1=%h instret=%0d exp 0/0/0", wb_valid, rdata1, instret);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      wb_stall = ($urandom_range(0, 3) == 0);
      drive(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 7)), $urandom);
      raddr1 = (pq.size() != 0 && $urandom_range(0, 1) == 1) ? pq[0].a : 5'($urandom_range(0, 7));
      raddr2 = 5'($urandom_range(0, 31));
      step();
      checks++;
      if (exu.exu_ready !== (pq.size() == 0 || !wb_stall)) begin
        failures++;
        $display("FAIL rnd_ready n=%0d got=%b", n, exu.exu_ready);
      end
      checks++;
      if (rdata1 !== m_read(raddr1) || rdata2 !== m_read(raddr2)) begin
        failures++;
        $display("FAIL rnd_read n=%0d r1=%0d got=%h exp=%h r2=%0d got=%h exp=%h",
                 n, raddr1, rdata1, m_read(raddr1), raddr2, rdata2, m_read(raddr2));
      end
      checks++;
      if (wb_valid !== m_wbv || instret !== m_ir) begin
        failures++;
        $display("FAIL rnd_count n=%0d wb_valid=%b exp=%b instret=%0d exp=%0d", n, wb_valid, m_wbv, instret, m_ir);
      end
      if (m_wbv) begin
        checks++;
        if (wb_waddr !== m_wba || wb_wdata !== m_wbd) begin
          failures++;
          $display("FAIL rnd_wb n=%0d waddr=%0d exp=%0d wdata=%h exp=%h", n, wb_waddr, m_wba, wb_wdata, m_wbd);
        end
      end
    end
  endtask

  initial begin
    drive(0, 0, 0, 0);
    test_reset();
    test_single();
    test_back_to_back();
    test_x0();
    test_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
